vx_sched_perf: RTL

Producer side of the scheduler's pipeline-performance bundle. It sits beside the warp scheduler and tracks two warp masks: active warps, and warps stalled by the scheduler. It also accumulates the scheduler-idle and scheduler-stall cycle counters. All four values drive the schedule modport of the pipeline perf interface, which the CSR/perf readout logic consumes.

---
 rtl/VX_gpu_pkg.sv | 23 ++
 rtl/VX_perf_accum.sv | 30 +++
 rtl/vx_sched_perf.sv | 90 +++++++++
 3 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared types and constants for the scheduler perf producer.
// Holds the per-cycle event struct, default widths and reset values.
// Ports: none (package).
package VX_gpu_pkg;

  localparam int DEF_NUM_WARPS     = 4;
  localparam int DEF_PERF_CTR_BITS = 44;

  typedef struct packed {
    logic idle;
    logic stall;
  } sched_perf_event_t;

  localparam sched_perf_event_t SCHED_PERF_EVENT_RST = '{idle: 1'b0, stall: 1'b0};
  localparam logic MASK_RST_BIT   = 1'b0;
  localparam logic PERF_EVENT_RST = 1'b0;

  // Width of an index into n items, never less than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_perf_accum.sv
// Two-stage event counter: registers the event bit, then adds it to a wrapping counter.
// Ports: clk, reset (sync, high), clear (sync), inc (event this cycle), count.
// Latency 2 cycles from inc to count; no backpressure, free-running.
module VX_perf_accum
  import VX_gpu_pkg::*;
#(
  parameter int CTR_W = DEF_PERF_CTR_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CTR_W-1:0] count
);

  logic inc_q;

  // Clearing the staged bit as well as the counter drops the event from
  // the clear cycle and the one already in flight.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      inc_q <= PERF_EVENT_RST;
      count <= '0;
    end else begin
      inc_q <= inc;
      count <= count + CTR_W'(inc_q);
    end
  end

endmodule

// File: rtl/vx_sched_perf.sv
// Scheduler perf producer: active/stalled warp masks plus idle/stall cycle counters.
// Ports: spawn/halt and stall set/clear events in; masks (next-state) and counters out.
// Masks update in 1 cycle, counters have 2-cycle latency; no handshakes, free-running.
module vx_sched_perf
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int CTR_W     = DEF_PERF_CTR_BITS,
  parameter int WID_W     = log2up(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spawn_valid,
  input  logic [NUM_WARPS-1:0] spawn_mask,
  input  logic                 halt_valid,
  input  logic [WID_W-1:0]     halt_wid,
  input  logic                 stall_set_valid,
  input  logic [WID_W-1:0]     stall_set_wid,
  input  logic                 stall_clr_valid,
  input  logic [WID_W-1:0]     stall_clr_wid,
  input  logic                 sched_valid,
  input  logic                 sched_ready,
  input  logic                 perf_clear,
  output logic [CTR_W-1:0]     sched_idles,
  output logic [CTR_W-1:0]     sched_stalls,
  output logic [NUM_WARPS-1:0] active_warps_n,
  output logic [NUM_WARPS-1:0] stalled_warps_n
);

  logic [NUM_WARPS-1:0] active_r;
  logic [NUM_WARPS-1:0] stalled_r;
  logic [NUM_WARPS-1:0] halt_oh;
  logic [NUM_WARPS-1:0] set_oh;
  logic [NUM_WARPS-1:0] clr_oh;
  sched_perf_event_t    ev;

  // One-hot decode only covers real warps, so an out-of-range wid
  // matches nothing and the event has no effect.
  always_comb begin
    halt_oh = '0;
    set_oh  = '0;
    clr_oh  = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      halt_oh[i] = halt_valid      && (halt_wid      == WID_W'(i));
      set_oh[i]  = stall_set_valid && (stall_set_wid == WID_W'(i));
      clr_oh[i]  = stall_clr_valid && (stall_clr_wid == WID_W'(i));
    end
  end

  // Spawn is OR'ed in after the halt, so it wins on the same warp; set is
  // OR'ed after the clear likewise. Stalls are masked by the new active set.
  always_comb begin
    active_warps_n  = (active_r & ~halt_oh) | (spawn_mask & {NUM_WARPS{spawn_valid}});
    stalled_warps_n = ((stalled_r & ~clr_oh) | set_oh) & active_warps_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_r  <= {NUM_WARPS{MASK_RST_BIT}};
      stalled_r <= {NUM_WARPS{MASK_RST_BIT}};
    end else begin
      active_r  <= active_warps_n;
      stalled_r <= stalled_warps_n;
    end
  end

  // Stage-0 events; suppressed during reset so nothing leaks into the counters.
  always_comb begin
    ev       = SCHED_PERF_EVENT_RST;
    ev.idle  = ~reset & ~sched_valid;
    ev.stall = ~reset & sched_valid & ~sched_ready;
  end

  VX_perf_accum #(.CTR_W(CTR_W)) u_idles (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (ev.idle),
    .count (sched_idles)
  );

  VX_perf_accum #(.CTR_W(CTR_W)) u_stalls (
    .clk   (clk),
    .reset (reset),
    .clear (perf_clear),
    .inc   (ev.stall),
    .count (sched_stalls)
  );

endmodule
